// File: rtl/data_prefill_if.sv
// Valid/ready data transfer bundle shared by producer and consumer sides.
interface data_prefill_if #(
    parameter int unsigned W = 16
) ();
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    // Producer drives data/valid and observes ready.
    modport master (
        output data,
        output valid,
        input  ready
    );

    // Consumer observes data/valid and drives ready.
    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/data_prefill.sv
// data_prefill: emits LEN copies of INIT_VAL after reset, then forwards din
// through a one-entry registered stage so the consumer sees a stream shifted
// by LEN transfers.
module data_prefill #(
    parameter int unsigned      LEN      = 5,
    parameter int unsigned      W_DIN    = 16,
    parameter logic [W_DIN-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    data_prefill_if.slave  din,
    data_prefill_if.master dout
);

    typedef enum logic {PRIME, PASS} state_t;

    localparam state_t RST_STATE = (LEN == 0) ? PASS : PRIME;

    state_t             state;
    state_t             state_nxt;
    logic               cnt_inc;
    logic               last_tok;
    logic [W_DIN-1:0]   reg_data;
    logic               reg_valid;
    logic               din_xfer;
    logic               dout_xfer;

    assign din_xfer  = din.valid && din.ready;
    assign dout_xfer = dout.valid && dout.ready;

    generate
        if (LEN > 0) begin : g_cnt
            localparam int unsigned   CW   = ($clog2(LEN + 1) > 0) ? $clog2(LEN + 1) : 1;
            localparam logic [CW-1:0] LAST = CW'(LEN - 1);

            logic [CW-1:0] cnt;

            // Prefill token counter; holds on the final token instead of wrapping.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                end else if (cnt_inc) begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign last_tok = (cnt == LAST);
        end else begin : g_nocnt
            assign last_tok = 1'b1;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; both valid and ready are forced low during reset.
    always_comb begin
        state_nxt  = state;
        cnt_inc    = 1'b0;
        dout.valid = 1'b0;
        dout.data  = reg_data;
        din.ready  = 1'b0;
        case (state)
            PRIME: begin
                dout.valid = !rst;
                dout.data  = INIT_VAL;
                if (!rst && dout.ready) begin
                    if (last_tok) begin
                        state_nxt = PASS;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            PASS: begin
                dout.valid = reg_valid;
                din.ready  = !rst && (!reg_valid || dout.ready);
            end
            default: begin
                state_nxt = RST_STATE;
            end
        endcase
    end

    // One-entry output stage: a new input wins over a drain in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_data  <= '0;
            reg_valid <= 1'b0;
        end else if (state == PASS) begin
            if (din_xfer) begin
                reg_data  <= din.data;
                reg_valid <= 1'b1;
            end else if (dout_xfer) begin
                reg_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_prefill.sv
// Bench for data_prefill: three instances (LEN 3, 0, 4) driven with random
// handshakes and checked cycle by cycle against a token-stream model.
module tb_data_prefill;

    localparam int          N = 3;
    localparam int          LENS [N]  = '{3, 0, 4};
    localparam logic [15:0] INITS [N] = '{16'hA5A5, 16'h0000, 16'h1234};

    logic clk = 1'b0;
    logic rst;

    logic [15:0] din_data   [N];
    logic        din_valid  [N];
    logic        dout_ready [N];
    logic        obs_dv     [N];
    logic [15:0] obs_dd     [N];
    logic        obs_dr     [N];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: remaining seed tokens plus FIFO of accepted words.
    int          prime_left [N];
    logic [15:0] q [N][$];

    always #5 clk = ~clk;

    data_prefill_if #(.W(16)) a_din ();
    data_prefill_if #(.W(16)) a_dout ();
    data_prefill_if #(.W(16)) z_din ();
    data_prefill_if #(.W(16)) z_dout ();
    data_prefill_if #(.W(16)) b_din ();
    data_prefill_if #(.W(16)) b_dout ();

    data_prefill #(.LEN(3), .W_DIN(16), .INIT_VAL(16'hA5A5)) u_a (
        .clk(clk), .rst(rst), .din(a_din), .dout(a_dout));
    data_prefill #(.LEN(0), .W_DIN(16), .INIT_VAL(16'h0000)) u_z (
        .clk(clk), .rst(rst), .din(z_din), .dout(z_dout));
    data_prefill #(.LEN(4), .W_DIN(16), .INIT_VAL(16'h1234)) u_b (
        .clk(clk), .rst(rst), .din(b_din), .dout(b_dout));

    assign a_din.data   = din_data[0];
    assign a_din.valid  = din_valid[0];
    assign a_dout.ready = dout_ready[0];
    assign obs_dv[0]    = a_dout.valid;
    assign obs_dd[0]    = a_dout.data;
    assign obs_dr[0]    = a_din.ready;

    assign z_din.data   = din_data[1];
    assign z_din.valid  = din_valid[1];
    assign z_dout.ready = dout_ready[1];
    assign obs_dv[1]    = z_dout.valid;
    assign obs_dd[1]    = z_dout.data;
    assign obs_dr[1]    = z_din.ready;

    assign b_din.data   = din_data[2];
    assign b_din.valid  = din_valid[2];
    assign b_dout.ready = dout_ready[2];
    assign obs_dv[2]    = b_dout.valid;
    assign obs_dd[2]    = b_dout.data;
    assign obs_dr[2]    = b_din.ready;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Check all instances against the model, advance the model, then move to the next negedge.
    task automatic tick();
        #1;
        for (int k = 0; k < N; k++) begin
            logic ev;
            logic er;
            if (rst) begin
                chk($sformatf("rst_dout_valid[%0d]", k), {15'd0, obs_dv[k]}, 16'd0);
                chk($sformatf("rst_din_ready[%0d]", k), {15'd0, obs_dr[k]}, 16'd0);
                prime_left[k] = LENS[k];
                q[k].delete();
            end else if (prime_left[k] > 0) begin
                chk($sformatf("prime_valid[%0d]", k), {15'd0, obs_dv[k]}, 16'd1);
                chk($sformatf("prime_data[%0d]", k), obs_dd[k], INITS[k]);
                chk($sformatf("prime_ready[%0d]", k), {15'd0, obs_dr[k]}, 16'd0);
                if (dout_ready[k]) prime_left[k]--;
            end else begin
                ev = (q[k].size() > 0);
                er = !ev || dout_ready[k];
                chk($sformatf("pass_valid[%0d]", k), {15'd0, obs_dv[k]}, {15'd0, ev});
                chk($sformatf("pass_ready[%0d]", k), {15'd0, obs_dr[k]}, {15'd0, er});
                if (ev) chk($sformatf("pass_data[%0d]", k), obs_dd[k], q[k][0]);
                if (ev && dout_ready[k]) void'(q[k].pop_front());
                if (er && din_valid[k]) q[k].push_back(din_data[k]);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_rand(input int pv, input int pr);
        for (int k = 0; k < N; k++) begin
            din_data[k]   = 16'($urandom);
            din_valid[k]  = ($urandom_range(0, 99) < pv);
            dout_ready[k] = ($urandom_range(0, 99) < pr);
        end
    endtask

    task automatic drive_all(input logic v, input logic r);
        for (int k = 0; k < N; k++) begin
            din_data[k]   = 16'($urandom);
            din_valid[k]  = v;
            dout_ready[k] = r;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_all(1'b0, 1'b0);
        @(negedge clk);
        tick();
        drive_all(1'b1, 1'b1);
        tick();

        // Prefill then streaming at full rate; covers the PRIME->PASS boundary.
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_all(1'b1, 1'b1);
            tick();
        end

        // Downstream ready toggling 1,0,1,0 with a continuous source.
        for (int i = 0; i < 12; i++) begin
            drive_all(1'b1, (i % 2) == 0);
            tick();
        end

        // Random traffic in PASS.
        for (int i = 0; i < 200; i++) begin
            drive_rand(60, 60);
            tick();
        end

        // Backpressure during prefill: tokens must hold, then exactly LEN seeds.
        rst = 1'b1;
        drive_all(1'b1, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_all(1'b1, 1'b0);
            tick();
        end
        for (int i = 0; i < 30; i++) begin
            drive_rand(70, 50);
            tick();
        end

        // Asynchronous reset mid-cycle after two seed transfers.
        rst = 1'b1;
        drive_all(1'b0, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("async_valid[%0d]", k), {15'd0, obs_dv[k]}, 16'd0);
            chk($sformatf("async_ready[%0d]", k), {15'd0, obs_dr[k]}, 16'd0);
        end
        @(negedge clk);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            drive_rand(50, 70);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
